ingress_rr_arbiter: RTL and testbench
=====================================

Name: ingress_rr_arbiter

Overview:
- Packet-level round-robin arbiter sharing one disassembler input between N_PORTS AXI-Stream sources (e.g. two MAC ports, or MAC plus host DMA).
- Grants one source at a time and holds the grant for the whole packet, up to and including the tlast beat.
- Sits directly upstream of the disassembler, so header/payload framing is never interleaved between sources.
- Admission can be paused between packets via pause_in (driven from SIMD lane FIFO fill levels).

Parameters:
- PHIT_SIZE, 512, stream data width in bits; PHIT_SIZE/8 keep bits.
- N_PORTS, 2, number of source streams (2..8).
- ID_W, 3, width of grant_id; must satisfy 2**ID_W >= N_PORTS.
- CNT_W, 32, packet counter width (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_tdata  in  N_PORTS*PHIT_SIZE  source data, port i at slice [i*PHIT_SIZE +: PHIT_SIZE]
- s_tkeep  in  N_PORTS*PHIT_SIZE/8  source byte keeps, same slicing
- s_tvalid  in  N_PORTS  source valid
- s_tlast  in  N_PORTS  source last
- s_tready  out  N_PORTS  source ready
- m_tdata  out  PHIT_SIZE  data to disassembler
- m_tkeep  out  PHIT_SIZE/8  keep to disassembler
- m_tvalid  out  1  valid to disassembler
- m_tlast  out  1  last to disassembler
- m_tready  in  1  ready from disassembler
- pause_in  in  1  when high, no new grant is issued
- grant_id  out  ID_W  index of current/last granted port
- busy  out  1  high while a packet grant is held

Behaviour:
- State machine: IDLE, LOCK.
- Registered: state, grant_id, rr_ptr (ID_W bits). All m_*/s_tready are combinational from the registered grant.
- Reset values: state=IDLE, grant_id=0, rr_ptr=0, busy=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, s_tready=0.
- IDLE:
  - m_tvalid=0, all s_tready=0, m_tdata/m_tkeep/m_tlast=0.
  - If pause_in=0 and any s_tvalid=1, choose the first valid port searching rr_ptr, rr_ptr+1, ... modulo N_PORTS.
  - On the next edge: grant_id <= chosen port, state <= LOCK, busy <= 1.
  - If pause_in=1, stay in IDLE regardless of s_tvalid.
  - Grant decision latency: 1 cycle from request to the first forwarded beat.
- LOCK:
  - m_tdata/m_tkeep/m_tlast/m_tvalid = the granted port's signals.
  - s_tready[grant_id] = m_tready; all other s_tready = 0.
  - pause_in is ignored, so a packet is never truncated.
  - A beat transfers when m_tvalid && m_tready.
  - On transfer of a beat with m_tlast=1: state <= IDLE, busy <= 0, rr_ptr <= (grant_id+1) mod N_PORTS. grant_id holds its value.
- Packets are back-to-back with exactly one idle cycle between them (the IDLE arbitration cycle). This bubble is required.
- Single-beat packet (tlast on first beat): LOCK lasts exactly the transfer cycle(s).
- Source deasserts tvalid mid-packet: grant is held indefinitely and m_tvalid=0. No timeout.
- m_tready low: the beat is held, and the source sees s_tready low.
- rst mid-packet: the grant is dropped at the next edge. The partial packet is not terminated; the downstream disassembler is reset by the same rst.
- Only the granted source's tvalid affects state while in LOCK.
- rr_ptr advances only on packet completion, not on grant.
- With N_PORTS not a power of two, rr_ptr and the search never index ports >= N_PORTS.

Optional Feature:
- Macro: ARB_PKT_STATS_EN.
- When defined:
  - Adds output pkt_count, width N_PORTS*CNT_W.
  - Port i's counter increments by 1 on each completed tlast transfer from port i.
  - Counters wrap modulo 2**CNT_W and reset to 0.
  - Adds input stats_clr (1 bit): synchronous clear of all counters; clear wins over a simultaneous increment.
- When undefined: no counters and no extra ports; behaviour otherwise identical.

Test Plan:
- Port0 sends a 4-beat packet, m_tready=1 → request at cycle 0; beats forwarded on cycles 1-4; busy falls after cycle 4; rr_ptr=1; grant_id stays 0.
- Ports 0 and 1 both continuously valid with 2-beat packets → grants alternate 0,1,0,1; exactly one idle cycle between packets; no beat from port1 appears inside a port0 packet.
- pause_in=1 while port1 is valid → stays IDLE, m_tvalid=0. Deassert pause_in → grant to port1 the next cycle. Assert pause_in during a port1 packet → packet completes all beats.
- m_tready toggled 1,0,0,1 mid-packet → m_tdata held stable while m_tready=0; s_tready[grant]=m_tready; other s_tready stay 0; no beat dropped or duplicated.
- rst asserted on beat 2 of a 5-beat port0 packet → next cycle state=IDLE, busy=0, m_tvalid=0, rr_ptr=0, grant_id=0.
- ARB_PKT_STATS_EN, CNT_W=4: 17 packets on port1 → pkt_count[port1]=1 (wrap). stats_clr pulsed together with a tlast transfer → counter reads 0.

Source files
------------

// File: rtl/ingress_rr_arbiter.sv
// Packet-level round-robin arbiter feeding one AXI-Stream disassembler input from N_PORTS sources.
// Optional per-port completed-packet counters are compiled in with `define ARB_PKT_STATS_EN.
module ingress_rr_arbiter #(
    parameter int PHIT_SIZE = 512,
    parameter int N_PORTS   = 2,
    parameter int ID_W      = 3,
    parameter int CNT_W     = 32
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef ARB_PKT_STATS_EN
    input  logic                           stats_clr,
    output logic [N_PORTS*CNT_W-1:0]       pkt_count,
`endif
    input  logic [N_PORTS*PHIT_SIZE-1:0]   s_tdata,
    input  logic [N_PORTS*PHIT_SIZE/8-1:0] s_tkeep,
    input  logic [N_PORTS-1:0]             s_tvalid,
    input  logic [N_PORTS-1:0]             s_tlast,
    output logic [N_PORTS-1:0]             s_tready,
    output logic [PHIT_SIZE-1:0]           m_tdata,
    output logic [PHIT_SIZE/8-1:0]         m_tkeep,
    output logic                           m_tvalid,
    output logic                           m_tlast,
    input  logic                           m_tready,
    input  logic                           pause_in,
    output logic [ID_W-1:0]                grant_id,
    output logic                           busy
);

    localparam int KEEP_W = PHIT_SIZE / 8;

    if ((1 << ID_W) < N_PORTS || N_PORTS < 2 || N_PORTS > 8 || CNT_W < 1) begin : g_bad_params
        $error("ingress_rr_arbiter: invalid N_PORTS/ID_W/CNT_W combination");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Handshake: a beat moves on either side only in a cycle where valid && ready;
    // in LOCK the granted source sees m_tready directly, every other source sees 0.
    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   grant_q;
    logic [ID_W-1:0]   grant_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_ptr_nxt;

    logic              req_found;
    logic [ID_W-1:0]   req_pick;

    logic [PHIT_SIZE-1:0] sel_tdata;
    logic [KEEP_W-1:0]    sel_tkeep;
    logic                 sel_tvalid;
    logic                 sel_tlast;
    logic                 pkt_done;

    // Mux of the currently granted port; grant_q never exceeds N_PORTS-1.
    always_comb begin
        sel_tdata  = '0;
        sel_tkeep  = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_tdata  = s_tdata[i*PHIT_SIZE +: PHIT_SIZE];
                sel_tkeep  = s_tkeep[i*KEEP_W +: KEEP_W];
                sel_tvalid = s_tvalid[i];
                sel_tlast  = s_tlast[i];
            end
        end
    end

    // Rotating search: offset k from rr_ptr, wrapped inside 0..N_PORTS-1 so
    // a non-power-of-two port count never touches a nonexistent port.
    always_comb begin
        req_found = 1'b0;
        req_pick  = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (!req_found && s_tvalid[i] &&
                    ((int'(rr_ptr) + k) % N_PORTS) == i) begin
                    req_found = 1'b1;
                    req_pick  = ID_W'(i);
                end
            end
        end
    end

    assign pkt_done = (state == ST_LOCK) && sel_tvalid && m_tready && sel_tlast;

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_q;
        rr_ptr_nxt = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (!pause_in && req_found) begin
                    state_nxt = ST_LOCK;
                    grant_nxt = req_pick;
                end
            end
            ST_LOCK: begin
                if (pkt_done) begin
                    state_nxt  = ST_IDLE;
                    rr_ptr_nxt = (grant_q == ID_W'(N_PORTS - 1)) ? '0 : grant_q + ID_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            rr_ptr  <= rr_ptr_nxt;
        end
    end

    always_comb begin
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
        if (state == ST_LOCK) begin
            m_tdata  = sel_tdata;
            m_tkeep  = sel_tkeep;
            m_tvalid = sel_tvalid;
            m_tlast  = sel_tlast;
            for (int i = 0; i < N_PORTS; i++) begin
                if (grant_q == ID_W'(i)) begin
                    s_tready[i] = m_tready;
                end
            end
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state == ST_LOCK);

`ifdef ARB_PKT_STATS_EN
    // Clear beats a coincident increment; counters wrap naturally at 2**CNT_W.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            pkt_count <= '0;
        end else if (pkt_done) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (grant_q == ID_W'(i)) begin
                    pkt_count[i*CNT_W +: CNT_W] <= pkt_count[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ingress_rr_arbiter.sv
// Randomized bench for ingress_rr_arbiter against a packet-level reference model.
// Also covers the ARB_PKT_STATS_EN counters when that macro is defined.
module tb_ingress_rr_arbiter;

    localparam int PHIT = 64;
    localparam int N    = 3;
    localparam int ID_W = 2;
    localparam int KW   = PHIT / 8;
`ifdef ARB_PKT_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N*PHIT-1:0] s_tdata;
    logic [N*KW-1:0]   s_tkeep;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tlast;
    logic [N-1:0]      s_tready;
    logic [PHIT-1:0]   m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic              pause_in;
    logic [ID_W-1:0]   grant_id;
    logic              busy;
`ifdef ARB_PKT_STATS_EN
    logic              stats_clr;
    logic [N*CNT_W-1:0] pkt_count;
`endif

    ingress_rr_arbiter #(
        .PHIT_SIZE(PHIT),
        .N_PORTS  (N),
        .ID_W     (ID_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef ARB_PKT_STATS_EN
        .stats_clr(stats_clr),
        .pkt_count(pkt_count),
`endif
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .pause_in (pause_in),
        .grant_id (grant_id),
        .busy     (busy)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [PHIT-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- source drivers ----------------
    logic [PHIT-1:0] src_data [N];
    logic [KW-1:0]   src_keep [N];
    bit              src_valid[N];
    bit              src_last [N];
    int              beats_left[N];
    bit              hs[N];

    // ---------------- reference model ----------------
    bit ref_lock;
    int ref_gid;
    int ref_ptr;
    int ref_cnt[N];
    int pkts_done[N];

    task automatic model_reset();
        ref_lock = 0;
        ref_gid  = 0;
        ref_ptr  = 0;
        for (int i = 0; i < N; i++) ref_cnt[i] = 0;
    endtask

    task automatic drive_sources(input bit [N-1:0] mask, input int p_valid);
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                beats_left[i]--;
                src_valid[i] = 0;
            end
            if (!src_valid[i] && mask[i] && $urandom_range(0, 99) < p_valid) begin
                if (beats_left[i] == 0) beats_left[i] = $urandom_range(1, 5);
                src_valid[i] = 1;
                src_data[i]  = {$urandom(), $urandom()};
                src_keep[i]  = KW'($urandom());
                src_last[i]  = (beats_left[i] == 1);
            end
            s_tdata[i*PHIT +: PHIT] = src_data[i];
            s_tkeep[i*KW +: KW]     = src_keep[i];
            s_tvalid[i]             = src_valid[i];
            s_tlast[i]              = src_last[i];
        end
    endtask

    // One cycle: drive on negedge, check combinational outputs, then advance the model to the posedge.
    task automatic run_cycle(input bit [N-1:0] mask, input int p_valid, input int p_pause,
                             input int p_ready, input int p_rst, input int p_clr);
        logic [N-1:0] exp_ready;
        bit done;
        @(negedge clk);
        drive_sources(mask, p_valid);
        pause_in = ($urandom_range(0, 99) < p_pause);
        m_tready = ($urandom_range(0, 99) < p_ready);
        rst      = ($urandom_range(0, 99) < p_rst);
`ifdef ARB_PKT_STATS_EN
        stats_clr = ($urandom_range(0, 99) < p_clr);
`endif
        #1;
        exp_ready = '0;
        if (ref_lock) exp_ready[ref_gid] = m_tready;
        check_val("busy",     64'(busy),     64'(ref_lock));
        check_val("grant_id", 64'(grant_id), 64'(ref_gid));
        check_val("m_tvalid", 64'(m_tvalid), ref_lock ? 64'(src_valid[ref_gid]) : 64'd0);
        check_val("m_tlast",  64'(m_tlast),  ref_lock ? 64'(src_last[ref_gid])  : 64'd0);
        check_val("m_tdata",  64'(m_tdata),  ref_lock ? 64'(src_data[ref_gid])  : 64'd0);
        check_val("m_tkeep",  64'(m_tkeep),  ref_lock ? 64'(src_keep[ref_gid])  : 64'd0);
        check_val("s_tready", 64'(s_tready), 64'(exp_ready));
`ifdef ARB_PKT_STATS_EN
        for (int i = 0; i < N; i++)
            check_val("pkt_count", 64'(pkt_count[i*CNT_W +: CNT_W]), 64'(ref_cnt[i]));
`endif
        // Every beat a source hands over must appear once, in order, on the output.
        for (int i = 0; i < N; i++) begin
            hs[i] = src_valid[i] && s_tready[i];
            if (hs[i]) exp_q.push_back(src_data[i]);
        end
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) check_val("beat_extra", 64'(m_tdata), 64'hDEAD);
            else check_val("beat_order", 64'(m_tdata), 64'(exp_q.pop_front()));
        end

        done = ref_lock && src_valid[ref_gid] && m_tready && src_last[ref_gid];
        if (rst) begin
            model_reset();
        end else begin
`ifdef ARB_PKT_STATS_EN
            if (stats_clr) begin
                for (int i = 0; i < N; i++) ref_cnt[i] = 0;
            end else if (done) begin
                ref_cnt[ref_gid] = (ref_cnt[ref_gid] + 1) % (1 << CNT_W);
            end
`endif
            if (!ref_lock) begin
                if (!pause_in) begin
                    for (int k = 0; k < N; k++) begin
                        if (src_valid[(ref_ptr + k) % N]) begin
                            ref_lock = 1;
                            ref_gid  = (ref_ptr + k) % N;
                            break;
                        end
                    end
                end
            end else if (done) begin
                ref_lock = 0;
                pkts_done[ref_gid]++;
                ref_ptr = (ref_gid + 1) % N;
            end
        end
    endtask

    task automatic run_phase(input int cycles, input bit [N-1:0] mask, input int p_valid,
                             input int p_pause, input int p_ready, input int p_rst, input int p_clr);
        for (int c = 0; c < cycles; c++)
            run_cycle(mask, p_valid, p_pause, p_ready, p_rst, p_clr);
    endtask

    initial begin
        rst = 1'b1;
        pause_in = 1'b0;
        m_tready = 1'b0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tvalid = '0;
        s_tlast = '0;
`ifdef ARB_PKT_STATS_EN
        stats_clr = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            src_data[i] = '0;
            src_keep[i] = '0;
            src_valid[i] = 0;
            src_last[i] = 0;
            beats_left[i] = 0;
            hs[i] = 0;
            pkts_done[i] = 0;
        end
        model_reset();
        repeat (2) @(posedge clk);

        run_phase(3,    3'b000, 0,   0,   100, 100, 0);  // reset values held
        run_phase(40,   3'b001, 100, 0,   100, 0,   0);  // port0 alone, full throughput
        run_phase(200,  3'b011, 100, 0,   100, 0,   0);  // ports 0/1 alternate
        run_phase(20,   3'b010, 100, 100, 100, 0,   0);  // paused: no grant
        run_phase(60,   3'b010, 100, 30,  100, 0,   0);  // pause toggling during packets
        run_phase(300,  3'b111, 80,  10,  50,  0,   0);  // ready back-pressure, 3 ports
        run_phase(1500, 3'b111, 70,  30,  60,  2,   3);  // mixed, with resets and clears
        run_phase(400,  3'b010, 100, 0,   100, 0,   0);  // long port1 run, counter wraps
        run_phase(400,  3'b101, 60,  20,  70,  0,   1);  // ports 0/2 wrap-around of rr_ptr

        // Drain: stop sources, let any packet in flight finish.
        run_phase(1,    3'b000, 0,   0,   100, 100, 0);
        run_phase(5,    3'b000, 0,   0,   100, 0,   0);
        check_val("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check_val("port0_pkts_seen", 64'(pkts_done[0] > 0), 64'd1);
        check_val("port1_pkts_seen", 64'(pkts_done[1] > 0), 64'd1);
        check_val("port2_pkts_seen", 64'(pkts_done[2] > 0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
